alloc_rsp_merger: RTL and testbench

// - Sits downstream of the dispatcher and the FDT, upstream of the alloc response FIFO.
// - Merges two unsynchronised alloc-response sources into one FIFO write port, at most one write per cycle:
//   - dispatcher fail responses;
//   - FDT allocation results (success or fail).
// - Buffers collisions in a small pending queue.
// - Generates the almost-full indication that the dispatcher uses for flow control.

---
 rtl/alloc_rsp_merger_if.sv | 50 +++++
 rtl/alloc_rsp_merger.sv | 116 +++++++++++
 tb/tb_alloc_rsp_merger.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alloc_rsp_merger_if.sv
// alloc_rsp_merger_if: bundles the dispatcher and FDT response inputs, the downstream FIFO write port and the status flags.
//   slave  : merger side (response and FIFO-status inputs in, FIFO write port and almost_full/overflow_err out)
//   master : environment side (mirror of slave)
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 10
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 3
`endif
`ifndef FIFO_PTR_WIDTH
`define FIFO_PTR_WIDTH 6
`endif
interface alloc_rsp_merger_if;
   logic                           disp_rsp_write_en;
   logic [`REQ_ID_WIDTH-1:0]       disp_rsp_id;
   logic [`ALL_PAGE_IDX_WIDTH-1:0] disp_rsp_page_idx;
   logic                           disp_rsp_fail;
   logic [`FAIL_REASON_WIDTH-1:0]  disp_rsp_fail_reason;
   logic                           fdt_rsp_valid;
   logic [`REQ_ID_WIDTH-1:0]       fdt_rsp_id;
   logic [`ALL_PAGE_IDX_WIDTH-1:0] fdt_rsp_page_idx;
   logic                           fdt_rsp_fail;
   logic [`FAIL_REASON_WIDTH-1:0]  fdt_rsp_fail_reason;
   logic                           rsp_fifo_full;
   logic [`FIFO_PTR_WIDTH:0]       rsp_fifo_data_count;
   logic                           rsp_fifo_write_en;
   logic [`REQ_ID_WIDTH-1:0]       rsp_fifo_id;
   logic [`ALL_PAGE_IDX_WIDTH-1:0] rsp_fifo_page_idx;
   logic                           rsp_fifo_fail;
   logic [`FAIL_REASON_WIDTH-1:0]  rsp_fifo_fail_reason;
   logic                           alloc_rsp_fifo_almost_full;
   logic                           overflow_err;
   modport slave (
      input  disp_rsp_write_en, disp_rsp_id, disp_rsp_page_idx, disp_rsp_fail, disp_rsp_fail_reason,
      input  fdt_rsp_valid, fdt_rsp_id, fdt_rsp_page_idx, fdt_rsp_fail, fdt_rsp_fail_reason,
      input  rsp_fifo_full, rsp_fifo_data_count,
      output rsp_fifo_write_en, rsp_fifo_id, rsp_fifo_page_idx, rsp_fifo_fail, rsp_fifo_fail_reason,
      output alloc_rsp_fifo_almost_full, overflow_err
   );
   modport master (
      output disp_rsp_write_en, disp_rsp_id, disp_rsp_page_idx, disp_rsp_fail, disp_rsp_fail_reason,
      output fdt_rsp_valid, fdt_rsp_id, fdt_rsp_page_idx, fdt_rsp_fail, fdt_rsp_fail_reason,
      output rsp_fifo_full, rsp_fifo_data_count,
      input  rsp_fifo_write_en, rsp_fifo_id, rsp_fifo_page_idx, rsp_fifo_fail, rsp_fifo_fail_reason,
      input  alloc_rsp_fifo_almost_full, overflow_err
   );
endinterface

// File: rtl/alloc_rsp_merger.sv
// alloc_rsp_merger: merges dispatcher and FDT alloc responses into one registered FIFO write port with a pending queue.
//   clk, rst (async, active-high); bus : alloc_rsp_merger_if.slave (inputs, FIFO write port, almost_full, sticky overflow_err)
//   ALLOC_RSP_MERGER_STATS_EN adds stat_ok_cnt, stat_fail_cnt, stat_drop_cnt (saturating) and stat_max_occ.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 10
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 3
`endif
`ifndef FIFO_PTR_WIDTH
`define FIFO_PTR_WIDTH 6
`endif
module alloc_rsp_merger #(
   parameter int PEND_DEPTH = 4,
   parameter int FIFO_DEPTH = 64,
   parameter int AF_MARGIN  = 8
) (
   input logic clk,
   input logic rst,
   alloc_rsp_merger_if.slave bus
`ifdef ALLOC_RSP_MERGER_STATS_EN
   ,
   output logic [15:0] stat_ok_cnt,
   output logic [15:0] stat_fail_cnt,
   output logic [15:0] stat_drop_cnt,
   output logic [$clog2(PEND_DEPTH+1)-1:0] stat_max_occ
`endif
);
   localparam int CW = $clog2(PEND_DEPTH + 1);
   localparam int PW = $clog2(PEND_DEPTH);
   localparam int SW = `FIFO_PTR_WIDTH + 2;
   typedef struct packed {
      logic [`REQ_ID_WIDTH-1:0]       id;
      logic [`ALL_PAGE_IDX_WIDTH-1:0] page;
      logic                           fail;
      logic [`FAIL_REASON_WIDTH-1:0]  reason;
   } rsp_t;
   typedef enum logic {BYPASS, DRAIN} state_t;
   state_t        state, state_next;
   rsp_t          mem [PEND_DEPTH];
   rsp_t          fdt_rsp, disp_rsp, head, wr_rsp;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] occ, occ_next;
   logic [CW:0]   space;
   logic          byp_path, deq, byp, enq_f, enq_d, keep_f, keep_d, drop_f, drop_d;
   assign fdt_rsp  = {bus.fdt_rsp_id, bus.fdt_rsp_page_idx, bus.fdt_rsp_fail, bus.fdt_rsp_fail_reason};
   assign disp_rsp = {bus.disp_rsp_id, bus.disp_rsp_page_idx, bus.disp_rsp_fail, bus.disp_rsp_fail_reason};
   assign head     = mem[rd_ptr];
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= BYPASS;
      else state <= state_next;
   // Arrivals in DRAIN are always enqueued, so an empty queue next cycle implies nothing arrived.
   always_comb state_next = occ_next != '0 ? DRAIN : BYPASS;
   always_comb begin
      byp_path = state == BYPASS && !bus.rsp_fifo_full;
      deq      = state == DRAIN && !bus.rsp_fifo_full && occ != '0;
      byp      = byp_path && (bus.fdt_rsp_valid || bus.disp_rsp_write_en);
   end
   // FDT wins the bypass slot; the slot freed by a dequeue is reusable in the same cycle.
   always_comb begin
      enq_f    = bus.fdt_rsp_valid && !byp_path;
      enq_d    = bus.disp_rsp_write_en && !(byp_path && !bus.fdt_rsp_valid);
      space    = (CW+1)'(PEND_DEPTH) - {1'b0, occ} + (CW+1)'(deq);
      keep_f   = enq_f && space != '0;
      keep_d   = enq_d && space > (CW+1)'(keep_f);
      drop_f   = enq_f && !keep_f;
      drop_d   = enq_d && !keep_d;
      occ_next = occ + CW'(keep_f) + CW'(keep_d) - CW'(deq);
      wr_rsp   = deq ? head : bus.fdt_rsp_valid ? fdt_rsp : disp_rsp;
   end
   always_ff @(posedge clk) begin
      if (keep_f) mem[wr_ptr] <= fdt_rsp;
      if (keep_d) mem[keep_f ? wr_ptr + 1'b1 : wr_ptr] <= disp_rsp;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_ptr                         <= '0;
         wr_ptr                         <= '0;
         occ                            <= '0;
         bus.rsp_fifo_write_en          <= 1'b0;
         bus.rsp_fifo_id                <= '0;
         bus.rsp_fifo_page_idx          <= '0;
         bus.rsp_fifo_fail              <= 1'b0;
         bus.rsp_fifo_fail_reason       <= '0;
         bus.alloc_rsp_fifo_almost_full <= 1'b0;
         bus.overflow_err               <= 1'b0;
      end else begin
         rd_ptr                         <= rd_ptr + PW'(deq);
         wr_ptr                         <= wr_ptr + PW'(keep_f) + PW'(keep_d);
         occ                            <= occ_next;
         bus.rsp_fifo_write_en          <= deq || byp;
         if (deq || byp)
            {bus.rsp_fifo_id, bus.rsp_fifo_page_idx, bus.rsp_fifo_fail, bus.rsp_fifo_fail_reason} <= wr_rsp;
         bus.alloc_rsp_fifo_almost_full <= SW'(bus.rsp_fifo_data_count) + SW'(occ_next) >= SW'(FIFO_DEPTH - AF_MARGIN);
         bus.overflow_err               <= bus.overflow_err || drop_f || drop_d;
      end
`ifdef ALLOC_RSP_MERGER_STATS_EN
   logic [16:0] drop_sum;
   assign drop_sum = {1'b0, stat_drop_cnt} + 17'(drop_f) + 17'(drop_d);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         stat_ok_cnt   <= '0;
         stat_fail_cnt <= '0;
         stat_drop_cnt <= '0;
         stat_max_occ  <= '0;
      end else begin
         if ((deq || byp) && !wr_rsp.fail) stat_ok_cnt <= stat_ok_cnt + 16'(stat_ok_cnt != 16'hFFFF);
         if ((deq || byp) && wr_rsp.fail) stat_fail_cnt <= stat_fail_cnt + 16'(stat_fail_cnt != 16'hFFFF);
         stat_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         if (occ_next > stat_max_occ) stat_max_occ <= occ_next;
      end
`endif
endmodule

// File: tb/tb_alloc_rsp_merger.sv
// tb_alloc_rsp_merger: directed checks of bypass, collision queueing, overflow, almost_full and reset for alloc_rsp_merger.
module tb_alloc_rsp_merger;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   int   fails = 0;
   alloc_rsp_merger_if bus ();
`ifdef ALLOC_RSP_MERGER_STATS_EN
   logic [15:0] s_ok, s_fail, s_drop;
   logic [2:0]  s_max;
`endif
   alloc_rsp_merger dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef ALLOC_RSP_MERGER_STATS_EN
      ,
      .stat_ok_cnt(s_ok),
      .stat_fail_cnt(s_fail),
      .stat_drop_cnt(s_drop),
      .stat_max_occ(s_max)
`endif
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic fdt(input logic v, input logic [7:0] id, input logic [9:0] page, input logic fail);
      bus.fdt_rsp_valid = v;
      bus.fdt_rsp_id = id;
      bus.fdt_rsp_page_idx = page;
      bus.fdt_rsp_fail = fail;
      bus.fdt_rsp_fail_reason = 3'd1;
   endtask
   task automatic disp(input logic v, input logic [7:0] id, input logic fail);
      bus.disp_rsp_write_en = v;
      bus.disp_rsp_id = id;
      bus.disp_rsp_page_idx = 10'h3;
      bus.disp_rsp_fail = fail;
      bus.disp_rsp_fail_reason = 3'd0;
   endtask
   initial begin
      fdt(0, 0, 0, 0);
      disp(0, 0, 0);
      bus.rsp_fifo_full = 0;
      bus.rsp_fifo_data_count = '0;
      tick();
      tick();
      chk("rst_we", bus.rsp_fifo_write_en, 0);
      chk("rst_id", bus.rsp_fifo_id, 0);
      chk("rst_af", bus.alloc_rsp_fifo_almost_full, 0);
      chk("rst_ovf", bus.overflow_err, 0);
      rst = 0;
      tick();
      chk("post_rst_we", bus.rsp_fifo_write_en, 0);
      // single FDT response bypasses with one cycle latency
      fdt(1, 5, 10'h12, 0);
      tick();
      fdt(0, 0, 0, 0);
      chk("byp_we", bus.rsp_fifo_write_en, 1);
      chk("byp_id", bus.rsp_fifo_id, 5);
      chk("byp_page", bus.rsp_fifo_page_idx, 10'h12);
      chk("byp_fail", bus.rsp_fifo_fail, 0);
      tick();
      chk("byp_idle_we", bus.rsp_fifo_write_en, 0);
      chk("byp_hold_id", bus.rsp_fifo_id, 5);
      // collision: FDT first, dispatcher next cycle
      fdt(1, 1, 10'h7, 0);
      disp(1, 2, 1);
      tick();
      fdt(0, 0, 0, 0);
      disp(0, 0, 0);
      chk("col1_we", bus.rsp_fifo_write_en, 1);
      chk("col1_id", bus.rsp_fifo_id, 1);
      tick();
      chk("col2_we", bus.rsp_fifo_write_en, 1);
      chk("col2_id", bus.rsp_fifo_id, 2);
      chk("col2_fail", bus.rsp_fifo_fail, 1);
      chk("col2_reason", bus.rsp_fifo_fail_reason, 0);
      tick();
      chk("col_idle_we", bus.rsp_fifo_write_en, 0);
      disp(1, 7, 0);
      tick();
      disp(0, 0, 0);
      chk("col_byp_we", bus.rsp_fifo_write_en, 1);
      chk("col_byp_id", bus.rsp_fifo_id, 7);
      // full for 6 cycles with 5 single arrivals: fifth is dropped
      bus.rsp_fifo_full = 1;
      for (int i = 0; i < 5; i++) begin
         fdt(1, 8'(10 + i), 10'h20, 0);
         tick();
         chk("full_we", bus.rsp_fifo_write_en, 0);
         if (i == 3) chk("ovf_before", bus.overflow_err, 0);
      end
      fdt(0, 0, 0, 0);
      chk("ovf_set", bus.overflow_err, 1);
      tick();
      chk("full6_we", bus.rsp_fifo_write_en, 0);
      bus.rsp_fifo_full = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("drain_we", bus.rsp_fifo_write_en, 1);
         chk("drain_id", bus.rsp_fifo_id, 10 + i);
      end
      tick();
      chk("drain_done_we", bus.rsp_fifo_write_en, 0);
      chk("drain_hold_id", bus.rsp_fifo_id, 13);
      chk("ovf_sticky", bus.overflow_err, 1);
      // queue 3 deep, then both sources at once: dispatcher is the one dropped
      bus.rsp_fifo_full = 1;
      for (int i = 0; i < 3; i++) begin
         fdt(1, 8'(40 + i), 10'h1, 0);
         tick();
      end
      fdt(1, 43, 10'h1, 0);
      disp(1, 44, 1);
      tick();
      fdt(0, 0, 0, 0);
      disp(0, 0, 0);
      bus.rsp_fifo_full = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("pair_drain_id", bus.rsp_fifo_id, 40 + i);
      end
      chk("pair_last_fail", bus.rsp_fifo_fail, 0);
      tick();
      chk("pair_done_we", bus.rsp_fifo_write_en, 0);
      // almost_full threshold 56 counts queued entries
      bus.rsp_fifo_full = 1;
      bus.rsp_fifo_data_count = 7'd55;
      fdt(1, 20, 10'h2, 0);
      tick();
      fdt(0, 0, 0, 0);
      chk("af_55_q1", bus.alloc_rsp_fifo_almost_full, 1);
      bus.rsp_fifo_full = 0;
      bus.rsp_fifo_data_count = 7'd54;
      tick();
      chk("af_54_q0", bus.alloc_rsp_fifo_almost_full, 0);
      chk("af_drain_id", bus.rsp_fifo_id, 20);
      bus.rsp_fifo_data_count = 7'd56;
      tick();
      chk("af_56_q0", bus.alloc_rsp_fifo_almost_full, 1);
      bus.rsp_fifo_data_count = 7'd0;
      tick();
      chk("af_0", bus.alloc_rsp_fifo_almost_full, 0);
      // asynchronous reset with 3 entries queued
      bus.rsp_fifo_full = 1;
      for (int i = 0; i < 3; i++) begin
         fdt(1, 8'(30 + i), 10'h5, 1);
         tick();
      end
      fdt(0, 0, 0, 0);
      rst = 1;
      #1;
      chk("arst_ovf", bus.overflow_err, 0);
      chk("arst_we", bus.rsp_fifo_write_en, 0);
      chk("arst_id", bus.rsp_fifo_id, 0);
      tick();
      rst = 0;
      bus.rsp_fifo_full = 0;
      tick();
      chk("arst_rel1_we", bus.rsp_fifo_write_en, 0);
      tick();
      chk("arst_rel2_we", bus.rsp_fifo_write_en, 0);
`ifdef ALLOC_RSP_MERGER_STATS_EN
      chk("st_rst_ok", s_ok, 0);
      chk("st_rst_drop", s_drop, 0);
`endif
      fdt(1, 50, 10'h9, 0);
      tick();
      fdt(0, 0, 0, 0);
      chk("arst_byp_id", bus.rsp_fifo_id, 50);
      chk("arst_byp_we", bus.rsp_fifo_write_en, 1);
      // 3 ok + 2 fail writes and one drop
      bus.rsp_fifo_full = 1;
      fdt(1, 60, 10'h0, 0);
      tick();
      fdt(1, 61, 10'h0, 0);
      tick();
      fdt(1, 62, 10'h0, 1);
      tick();
      fdt(1, 63, 10'h0, 1);
      tick();
      fdt(1, 64, 10'h0, 1);
      tick();
      fdt(0, 0, 0, 0);
      bus.rsp_fifo_full = 0;
      for (int i = 0; i < 4; i++) tick();
      chk("st_last_id", bus.rsp_fifo_id, 63);
      tick();
      chk("st_idle_we", bus.rsp_fifo_write_en, 0);
`ifdef ALLOC_RSP_MERGER_STATS_EN
      chk("st_ok", s_ok, 3);
      chk("st_fail", s_fail, 2);
      chk("st_drop", s_drop, 1);
      chk("st_max", s_max, 4);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
